sublime_voice_sched: RTL and testbench
======================================

SUBLIME_VOICE_SCHED -- requirements
Module: sublime_voice_sched

Interface
REQ-001 SHALL have parameter NUM_VOICES, default 8, number of time-multiplexed voices (power of 2, >=2).
REQ-002 SHALL have parameter CLKS_PER_SAMPLE, default 1024, clk cycles per output sample frame (>= 4*NUM_VOICES+2).
REQ-003 SHALL have parameter DONE_TIMEOUT, default 64, max WAIT_DONE cycles per voice.
REQ-004 SHALL use one clock; reset is asynchronous and active-low.
REQ-005 SHALL have port clk, input, 1, sole clock.
REQ-006 SHALL have port rst, input, 1, asynchronous active-low reset.
REQ-007 SHALL have port enable, input, 1, run sample-frame scheduling.
REQ-008 SHALL have port voice_enable, input, NUM_VOICES, per-voice enable; bit i = voice i.
REQ-009 SHALL have port active_voice_done, input, 1, datapath finished current voice.
REQ-010 SHALL have port err_clr, input, 1, clears sticky flags.
REQ-011 SHALL have port active_voice, output, $clog2(NUM_VOICES), voice being processed.
REQ-012 SHALL have port active_voice_changed, output, 1, one-cycle pulse on new voice.
REQ-013 SHALL have port frame_start, output, 1, one-cycle pulse, frame begun.
REQ-014 SHALL have port frame_done, output, 1, one-cycle pulse, mixer may latch sample.
REQ-015 SHALL have port busy, output, 1, high whenever state != IDLE.
REQ-016 SHALL have ports overrun and timeout_err, output, 1 each, sticky error flags.

Function
REQ-017 Tick counter SHALL count 0..CLKS_PER_SAMPLE-1 and wrap while enable=1; held at 0 while enable=0; tick = enable and count==CLKS_PER_SAMPLE-1.
REQ-018 FSM states SHALL be IDLE, SELECT, WAIT_DONE, NEXT, FINISH; all outputs registered.
REQ-019 IDLE + tick SHALL go to SELECT with voice index 0; frame_start high in that first SELECT cycle.
REQ-020 SELECT SHALL go to WAIT_DONE if voice_enable[index]=1 (active_voice=index, active_voice_changed high in first WAIT_DONE cycle), else to NEXT with active_voice unchanged, no pulse.
REQ-021 WAIT_DONE SHALL ignore active_voice_done in its first cycle; from second cycle, done=1 -> NEXT.
REQ-022 WAIT_DONE SHALL, after DONE_TIMEOUT cycles without done, set timeout_err and go to NEXT.
REQ-023 NEXT SHALL go to FINISH if index==NUM_VOICES-1, else increment index and go to SELECT; no wrap past last voice.
REQ-024 FINISH SHALL pulse frame_done for one cycle and return to IDLE.
REQ-025 Tick while busy SHALL be dropped and set overrun; current frame continues.
REQ-026 enable falling mid-frame SHALL let the frame complete; no new frame starts.
REQ-027 err_clr SHALL clear overrun and timeout_err; simultaneous set and clear -> set wins.
REQ-028 voice_enable SHALL be sampled per voice in its SELECT cycle only.

Reset
REQ-029 rst low SHALL asynchronously force IDLE, index 0, tick counter 0, and all outputs 0, including mid-frame.

Structure
REQ-030 State encoding SHALL be a typedef in shared package sublime_pkg, alongside voice-index width helper.
REQ-031 Tick counter SHALL be sub-module sublime_sample_tick (enable in, tick out).

Verification (NUM_VOICES=4, CLKS_PER_SAMPLE=64, DONE_TIMEOUT=16)
REQ-032 All voices enabled, done 1 cycle after each changed pulse -> changed pulses at frame_start+1,+5,+9,+13; frame_done at frame_start+16; frames every 64 cycles.
REQ-033 voice_enable=4'b0101 -> changed only for voices 0 and 2; disabled voices cost 2 cycles each; frame_done at frame_start+12.
REQ-034 done never asserted for voice 1 -> timeout_err=1 after 16 WAIT_DONE cycles; voices 2,3 still processed; err_clr clears it.
REQ-035 done withheld until the next tick occurs -> overrun=1, tick dropped, no second frame_start during frame.
REQ-036 rst low during WAIT_DONE of voice 2 -> next cycle busy=0, active_voice=0, all pulses 0; after release, first frame_start 64 cycles later.

Source files
------------

// File: rtl/sublime_pkg.sv
// Shared types for the voice scheduler: FSM state encoding
// and the voice-index width helper.
package sublime_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SELECT,
    WAIT_DONE,
    NEXT,
    FINISH
  } state_e;

  function automatic int vidx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/sublime_voice_sched_if.sv
// Control/status bundle between the voice scheduler
// and the voice datapath / mixer.
interface sublime_voice_sched_if #(
  parameter int NUM_VOICES = 8
);
  import sublime_pkg::*;

  localparam int VW = vidx_w(NUM_VOICES);

  logic                  enable;
  logic [NUM_VOICES-1:0] voice_enable;
  logic                  active_voice_done;
  logic                  err_clr;
  logic [VW-1:0]         active_voice;
  logic                  active_voice_changed;
  logic                  frame_start;
  logic                  frame_done;
  logic                  busy;
  logic                  overrun;
  logic                  timeout_err;

  modport master (
    output enable, voice_enable,
    output active_voice_done, err_clr,
    input  active_voice, active_voice_changed,
    input  frame_start, frame_done, busy,
    input  overrun, timeout_err
  );

  modport slave (
    input  enable, voice_enable,
    input  active_voice_done, err_clr,
    output active_voice, active_voice_changed,
    output frame_start, frame_done, busy,
    output overrun, timeout_err
  );

endinterface

// File: rtl/sublime_sample_tick.sv
// Sample-frame timebase: counts clk cycles and pulses tick
// on the last cycle of every frame while enabled.
module sublime_sample_tick #(
  parameter int CLKS_PER_SAMPLE = 1024
) (
  input  logic clk,
  input  logic rst,
  input  logic enable,
  output logic tick
);

  localparam int CW = $clog2(CLKS_PER_SAMPLE);
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_SAMPLE - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = '0;
    if (enable)
      cnt_d = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
  end

  assign tick = enable && (cnt_q == LAST);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) cnt_q <= '0;
    else      cnt_q <= cnt_d;
  end

endmodule

// File: rtl/sublime_voice_sched.sv
// Per-frame voice sequencer: walks every enabled voice once per
// sample frame and hands each to the datapath until it reports done.
module sublime_voice_sched
  import sublime_pkg::*;
#(
  parameter int NUM_VOICES      = 8,
  parameter int CLKS_PER_SAMPLE = 1024,
  parameter int DONE_TIMEOUT    = 64
) (
  input logic                  clk,
  input logic                  rst,
  sublime_voice_sched_if.slave bus
);

  localparam int VW = vidx_w(NUM_VOICES);
  localparam int TW = $clog2(DONE_TIMEOUT + 1);
  localparam logic [VW-1:0] LAST_V = VW'(NUM_VOICES - 1);
  localparam logic [TW-1:0] LAST_W = TW'(DONE_TIMEOUT - 1);

  logic tick;

  sublime_sample_tick #(
    .CLKS_PER_SAMPLE(CLKS_PER_SAMPLE)
  ) u_tick (
    .clk    (clk),
    .rst    (rst),
    .enable (bus.enable),
    .tick   (tick)
  );

  state_e        state_q, state_d;
  logic [VW-1:0] idx_q, idx_d;
  logic [TW-1:0] wcnt_q, wcnt_d;
  logic [VW-1:0] av_q, av_d;
  logic          chg_q, chg_d;
  logic          fs_q, fs_d;
  logic          fd_q, fd_d;
  logic          busy_q, busy_d;
  logic          ovr_q, ovr_d;
  logic          to_q, to_d;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    wcnt_d  = wcnt_q;
    av_d    = av_q;
    chg_d   = 1'b0;
    fs_d    = 1'b0;
    fd_d    = 1'b0;
    ovr_d   = ovr_q & ~bus.err_clr;
    to_d    = to_q & ~bus.err_clr;
    // a frame boundary arriving mid-frame is lost, not queued
    if (tick && state_q != IDLE)
      ovr_d = 1'b1;
    unique case (state_q)
      IDLE: begin
        if (tick) begin
          state_d = SELECT;
          idx_d   = '0;
          fs_d    = 1'b1;
        end
      end
      SELECT: begin
        if (bus.voice_enable[idx_q]) begin
          state_d = WAIT_DONE;
          av_d    = idx_q;
          chg_d   = 1'b1;
          wcnt_d  = '0;
        end else begin
          state_d = NEXT;
        end
      end
      WAIT_DONE: begin
        // done in the first cycle belongs to the previous voice
        if (wcnt_q != '0 && bus.active_voice_done) begin
          state_d = NEXT;
        end else if (wcnt_q == LAST_W) begin
          state_d = NEXT;
          to_d    = 1'b1;
        end else begin
          wcnt_d  = wcnt_q + 1'b1;
        end
      end
      NEXT: begin
        if (idx_q == LAST_V) begin
          state_d = FINISH;
          fd_d    = 1'b1;
        end else begin
          state_d = SELECT;
          idx_d   = idx_q + 1'b1;
        end
      end
      FINISH: state_d = IDLE;
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      wcnt_q  <= '0;
      av_q    <= '0;
      chg_q   <= 1'b0;
      fs_q    <= 1'b0;
      fd_q    <= 1'b0;
      busy_q  <= 1'b0;
      ovr_q   <= 1'b0;
      to_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      wcnt_q  <= wcnt_d;
      av_q    <= av_d;
      chg_q   <= chg_d;
      fs_q    <= fs_d;
      fd_q    <= fd_d;
      busy_q  <= busy_d;
      ovr_q   <= ovr_d;
      to_q    <= to_d;
    end
  end

  assign bus.active_voice         = av_q;
  assign bus.active_voice_changed = chg_q;
  assign bus.frame_start          = fs_q;
  assign bus.frame_done           = fd_q;
  assign bus.busy                 = busy_q;
  assign bus.overrun              = ovr_q;
  assign bus.timeout_err          = to_q;

endmodule

// File: tb/tb_sublime_voice_sched.sv
// Directed bench for sublime_voice_sched (4 voices, 64 clk/frame,
// 16-cycle done timeout): frame vectors plus corner sequences.
module tb_sublime_voice_sched;

  localparam int NV  = 4;
  localparam int CPS = 64;
  localparam int DTO = 16;
  localparam logic [4:0] NEVER = 5'd31;

  logic clk = 1'b0;
  logic rst = 1'b0;

  sublime_voice_sched_if #(.NUM_VOICES(NV)) bus ();

  sublime_voice_sched #(
    .NUM_VOICES      (NV),
    .CLKS_PER_SAMPLE (CPS),
    .DONE_TIMEOUT    (DTO)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    string        name;
    logic [3:0]   ve;
    logic [19:0]  dly;
    logic [127:0] chg;
    int           fd;
    logic         to;
    logic [1:0]   av;
  } vec_t;

  vec_t rows [8];
  int nerr = 0;
  int nchk = 0;
  int cyc  = 0;
  int last_fs = 0;

  task automatic step();
    @(negedge clk);
    cyc++;
  endtask

  task automatic chk(input string nm, input logic [127:0] act,
                     input logic [127:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [7:0] outs();
    return {bus.busy, bus.active_voice, bus.active_voice_changed,
            bus.frame_start, bus.frame_done, bus.overrun,
            bus.timeout_err};
  endfunction

  task automatic wait_fs(input int max, output int n);
    n = 0;
    while (!bus.frame_start && n < max) begin
      step();
      n++;
    end
  endtask

  // Observe one frame from its frame_start cycle (k=0), acting as
  // the datapath: done pulses dly cycles after each changed pulse.
  task automatic run_window(input int len, input logic [19:0] dly,
                            input int en_off_k,
                            output logic [127:0] chg,
                            output logic [127:0] to_tr,
                            output int fd_off, output int n_fs);
    int done_at;
    logic [4:0] d;
    done_at = -1;
    chg = '0;
    to_tr = '0;
    fd_off = -1;
    n_fs = 0;
    for (int k = 0; k < len; k++) begin
      if (k > 0 && bus.frame_start) n_fs++;
      if (bus.frame_done && fd_off < 0) fd_off = k;
      to_tr[k] = bus.timeout_err;
      if (bus.active_voice_changed) begin
        chg[k] = 1'b1;
        d = dly[int'(bus.active_voice)*5 +: 5];
        if (d != NEVER) done_at = k + int'(d);
      end
      bus.active_voice_done = (k == done_at);
      if (k == en_off_k) bus.enable = 1'b0;
      step();
    end
    bus.active_voice_done = 1'b0;
  endtask

  initial begin
    logic [127:0] chg, to_tr;
    int fd_off, n_fs, n;

    rows[0] = '{"all_on", 4'hF, {5'd1, 5'd1, 5'd1, 5'd1},
                128'h2222, 16, 1'b0, 2'd3};
    rows[1] = '{"v0101", 4'h5, {5'd1, 5'd1, 5'd1, 5'd1},
                128'h82, 12, 1'b0, 2'd2};
    rows[2] = '{"none", 4'h0, {5'd1, 5'd1, 5'd1, 5'd1},
                128'h0, 8, 1'b0, 2'd2};
    rows[3] = '{"v3_only", 4'h8, {5'd3, 5'd1, 5'd1, 5'd1},
                128'h80, 12, 1'b0, 2'd3};
    rows[4] = '{"v1_first_only", 4'hF, {5'd1, 5'd1, 5'd0, 5'd1},
                128'h08800022, 30, 1'b1, 2'd3};
    rows[5] = '{"dly2", 4'hF, {5'd2, 5'd2, 5'd2, 5'd2},
                128'h10842, 20, 1'b0, 2'd3};
    rows[6] = '{"v2_last_cyc", 4'hF, {5'd1, 5'd15, 5'd1, 5'd1},
                128'h08000222, 30, 1'b0, 2'd3};
    rows[7] = '{"v2_too_late", 4'hF, {5'd1, 5'd16, 5'd1, 5'd1},
                128'h08000222, 30, 1'b1, 2'd3};

    bus.enable = 1'b1;
    bus.voice_enable = rows[0].ve;
    bus.active_voice_done = 1'b0;
    bus.err_clr = 1'b0;

    step();
    step();
    chk("reset_outs", 128'(outs()), 128'h0);
    rst = 1'b1;
    wait_fs(200, n);
    chk("first_fs_latency", n, CPS);
    last_fs = cyc;

    for (int i = 0; i < 8; i++) begin
      bus.voice_enable = rows[i].ve;
      if (i > 0) begin
        wait_fs(200, n);
        chk({rows[i].name, "_gap"}, cyc - last_fs, CPS);
        last_fs = cyc;
      end
      chk({rows[i].name, "_busy0"}, 128'(bus.busy), 128'h1);
      run_window(41, rows[i].dly, -1, chg, to_tr, fd_off, n_fs);
      chk({rows[i].name, "_chg"}, chg, rows[i].chg);
      chk({rows[i].name, "_fd"}, fd_off, rows[i].fd);
      chk({rows[i].name, "_nfs"}, n_fs, 0);
      chk({rows[i].name, "_to"}, 128'(bus.timeout_err),
          128'(rows[i].to));
      chk({rows[i].name, "_ovr"}, 128'(bus.overrun), 128'h0);
      chk({rows[i].name, "_av"}, 128'(bus.active_voice),
          128'(rows[i].av));
      chk({rows[i].name, "_idle"}, 128'(bus.busy), 128'h0);
      bus.err_clr = 1'b1;
      step();
      bus.err_clr = 1'b0;
      chk({rows[i].name, "_to_clr"}, 128'(bus.timeout_err), 128'h0);
    end

    // frame longer than the sample period: tick lands while busy
    bus.voice_enable = 4'hF;
    wait_fs(200, n);
    chk("ovr_gap", cyc - last_fs, CPS);
    last_fs = cyc;
    run_window(76, {NEVER, NEVER, NEVER, NEVER}, -1,
               chg, to_tr, fd_off, n_fs);
    chk("ovr_chg", chg, 128'h0080_0020_0008_0002);
    chk("ovr_fd", fd_off, 72);
    chk("ovr_nfs", n_fs, 0);
    chk("ovr_flag", 128'(bus.overrun), 128'h1);
    chk("ovr_to_flag", 128'(bus.timeout_err), 128'h1);
    wait_fs(200, n);
    chk("ovr_next_fs", cyc - last_fs, 2 * CPS);

    // enable drops mid-frame: frame finishes, nothing new starts
    run_window(100, {NEVER, NEVER, NEVER, NEVER}, 3,
               chg, to_tr, fd_off, n_fs);
    chk("enoff_fd", fd_off, 72);
    chk("enoff_nfs", n_fs, 0);
    wait_fs(150, n);
    chk("enoff_no_fs", n, 150);
    bus.err_clr = 1'b1;
    step();
    bus.err_clr = 1'b0;
    chk("enoff_clr", 128'({bus.overrun, bus.timeout_err}), 128'h0);

    // re-enable; timeout coincides with a held err_clr
    bus.voice_enable = 4'b0010;
    bus.enable = 1'b1;
    wait_fs(200, n);
    chk("enon_latency", n, CPS);
    last_fs = cyc;
    bus.err_clr = 1'b1;
    run_window(30, {NEVER, NEVER, NEVER, NEVER}, -1,
               chg, to_tr, fd_off, n_fs);
    bus.err_clr = 1'b0;
    chk("setwins_chg", chg, 128'h8);
    chk("setwins_fd", fd_off, 24);
    chk("setwins_to", 128'(to_tr[21:17]), 128'b00100);

    // async reset during voice 2's WAIT_DONE
    bus.voice_enable = 4'hF;
    wait_fs(200, n);
    chk("rst_gap", cyc - last_fs, CPS);
    run_window(9, {5'd1, 5'd1, 5'd1, 5'd1}, -1,
               chg, to_tr, fd_off, n_fs);
    chk("rst_pre_av", 128'({bus.active_voice,
        bus.active_voice_changed}), 128'b101);
    rst = 1'b0;
    #1;
    chk("rst_async", 128'(outs()), 128'h0);
    step();
    chk("rst_held", 128'(outs()), 128'h0);
    rst = 1'b1;
    wait_fs(200, n);
    chk("rst_release_fs", n, CPS);
    chk("rst_release_av", 128'(bus.active_voice), 128'h0);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
